// File: rtl/rv_pkg.sv
// Shared types and sizes for the RV32 register-file write scheduler.
// Latency: n/a. Backpressure: n/a.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } buf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations; raises the issue stall on RAW/WAW.
// Latency: stall is combinational; set/clear take effect at the next clock edge.
// Backpressure: none of its own; iss_stall is the backpressure it produces for decode.
module rf_scoreboard
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic              iss_use_rs1,
    input  logic              iss_use_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_long,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    output logic              iss_stall
);

    localparam logic [NREG-1:0] X0_MASK = ~(NREG'(1));

    logic [NREG-1:0] pend;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // No bypass: a register written this cycle still blocks issue.
    assign iss_stall = iss_valid & ((iss_use_rs1 & pend[iss_rs1]) |
                                    (iss_use_rs2 & pend[iss_rs2]) |
                                    pend[iss_rd]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && iss_long && !iss_stall && (iss_rd != '0))
            set_vec = NREG'(1) << iss_rd;
        if (clr_en)
            clr_vec = NREG'(1) << clr_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= '0;
        else
            pend <= ((pend & ~clr_vec) | set_vec) & X0_MASK;
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Shares the register-file write port between pipeline writeback (priority) and a 1-entry long-unit buffer.
// Latency: pipeline write is combinational; a long result writes 1..STARVE_LIMIT+1 cycles after acceptance.
// Backpressure: lu_ready drops while the buffer is occupied; wb_hold steals one WB slot when the buffer starves.
module rf_wb_sched
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic              iss_use_rs1,
    input  logic              iss_use_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_long,
    output logic              iss_stall,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    output logic              wb_hold,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_wd,
    output logic              lu_ready,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wr,
    output logic [XLEN-1:0]   rf_wd
);

    localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

    buf_state_t        state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [REG_AW-1:0] buf_rd;
    logic [XLEN-1:0]   buf_wd;
    logic              capture;
    logic              buf_wr;
    logic              slot_free;
    logic              wen_raw;

    assign slot_free = !wb_valid || !wb_we || (wb_rd == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            cnt    <= '0;
            buf_rd <= '0;
            buf_wd <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                buf_rd <= lu_rd;
                buf_wd <= lu_wd;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lu_ready  = 1'b0;
        wb_hold   = 1'b0;
        capture   = 1'b0;
        buf_wr    = 1'b0;
        case (state)
            EMPTY: begin
                lu_ready = 1'b1;
                if (lu_valid) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (slot_free) begin
                    buf_wr    = 1'b1;
                    state_nxt = EMPTY;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FORCE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FORCE: begin
                // Pipeline is frozen and re-presents its result next cycle.
                wb_hold   = 1'b1;
                buf_wr    = 1'b1;
                state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        if (buf_wr) begin
            wen_raw = (buf_rd != '0);
            rf_wr   = buf_rd;
            rf_wd   = buf_wd;
        end else begin
            wen_raw = !slot_free;
            rf_wr   = wb_rd;
            rf_wd   = wb_wd;
        end
    end

    // The pipeline path is combinational, so it must be gated explicitly while in reset.
    assign rf_wen = wen_raw & rst_n;

    rf_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_use_rs1 (iss_use_rs1),
        .iss_use_rs2 (iss_use_rs2),
        .iss_rd      (iss_rd),
        .iss_long    (iss_long),
        .clr_en      (buf_wr),
        .clr_rd      (buf_rd),
        .iss_stall   (iss_stall)
    );

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized bench for rf_wb_sched: a reference model predicts each cycle's outputs into a queue,
// and a monitor pops and compares them against the DUT on the falling edge.
module tb_rf_wb_sched;
    import rv_pkg::*;

    localparam int LIMIT  = 4;
    localparam int NCYC   = 3600;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iss_valid, iss_use_rs1, iss_use_rs2, iss_long;
    logic [REG_AW-1:0] iss_rs1, iss_rs2, iss_rd;
    logic              iss_stall;
    logic              wb_valid, wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_wd;
    logic              wb_hold;
    logic              lu_valid;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_wd;
    logic              lu_ready;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_wr;
    logic [XLEN-1:0]   rf_wd;

    rf_wb_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
        .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .wb_hold(wb_hold),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .rf_wen(rf_wen), .rf_wr(rf_wr), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wen;
        logic [REG_AW-1:0] wr;
        logic [XLEN-1:0]   wd;
        logic              stall;
        logic              hold;
        logic              rdy;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference state: pending destinations, and the one buffered long result with its age
    // (age 1 = first cycle after acceptance; it must land by age LIMIT+1).
    bit                m_pend[NREG];
    bit                m_have;
    int                m_age;
    logic [REG_AW-1:0] m_rd;
    logic [XLEN-1:0]   m_wd;
    bit                prev_hold;
    int                n_force, n_rst_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_wen", 32'(rf_wen), 32'(e.wen));
                if (e.wen) begin
                    chk("rf_wr", 32'(rf_wr), 32'(e.wr));
                    chk("rf_wd", rf_wd, e.wd);
                end
                chk("iss_stall", 32'(iss_stall), 32'(e.stall));
                chk("wb_hold", 32'(wb_hold), 32'(e.hold));
                chk("lu_ready", 32'(lu_ready), 32'(e.rdy));
            end
        end
    end

    task automatic model_cycle(input bit in_rst);
        exp_t e;
        bit   pipe_w, drain;
        e.wen = 1'b0; e.wr = '0; e.wd = '0; e.stall = 1'b0; e.hold = 1'b0; e.rdy = 1'b1;
        if (in_rst) begin
            if (m_have) n_rst_held++;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_have    = 1'b0;
            m_age     = 0;
            prev_hold = 1'b0;
            exp_q.push_back(e);
            return;
        end
        e.stall = iss_valid && ((iss_use_rs1 && m_pend[iss_rs1]) ||
                                (iss_use_rs2 && m_pend[iss_rs2]) || m_pend[iss_rd]);
        pipe_w = wb_valid && wb_we && (wb_rd != 0);
        e.rdy  = !m_have;
        drain  = 1'b0;
        if (m_have) begin
            if (m_age == LIMIT + 1) begin
                e.hold = 1'b1;
                drain  = 1'b1;
                n_force++;
            end else if (!pipe_w) begin
                drain = 1'b1;
            end
        end
        if (drain) begin
            e.wen = (m_rd != 0);
            e.wr  = m_rd;
            e.wd  = m_wd;
        end else begin
            e.wen = pipe_w;
            e.wr  = wb_rd;
            e.wd  = wb_wd;
        end
        exp_q.push_back(e);

        if (drain) begin
            m_pend[m_rd] = 1'b0;
            m_have       = 1'b0;
        end else if (m_have) begin
            m_age++;
        end else if (lu_valid) begin
            m_have = 1'b1;
            m_rd   = lu_rd;
            m_wd   = lu_wd;
            m_age  = 1;
        end
        if (iss_valid && iss_long && !e.stall && iss_rd != 0)
            m_pend[iss_rd] = 1'b1;
        prev_hold = e.hold;
    endtask

    initial begin
        bit do_rst;
        int phase, wb_pct;
        rst_n = 1'b0;
        iss_valid = 0; iss_use_rs1 = 0; iss_use_rs2 = 0; iss_long = 0;
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        wb_valid = 0; wb_we = 0; wb_rd = '0; wb_wd = '0;
        lu_valid = 0; lu_rd = '0; lu_wd = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_have = 0; m_age = 0; prev_hold = 0; n_force = 0; n_rst_held = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            do_rst = (cyc < 3) ||
                     (cyc > 200 && m_have && $urandom_range(0, 39) == 0);
            phase  = (cyc / 400) % 3;
            wb_pct = (phase == 0) ? 97 : (phase == 1) ? 15 : 60;

            iss_valid   = ($urandom_range(0, 99) < 75);
            iss_rs1     = REG_AW'($urandom_range(0, 7));
            iss_rs2     = REG_AW'($urandom_range(0, 7));
            iss_rd      = REG_AW'($urandom_range(0, 7));
            iss_use_rs1 = $urandom_range(0, 1) == 1;
            iss_use_rs2 = $urandom_range(0, 1) == 1;
            iss_long    = ($urandom_range(0, 99) < 40);

            if (!prev_hold) begin
                wb_valid = ($urandom_range(0, 99) < wb_pct);
                wb_we    = ($urandom_range(0, 99) < 92);
                wb_rd    = ($urandom_range(0, 99) < 6) ? '0 : REG_AW'($urandom_range(1, 31));
                wb_wd    = $urandom;
            end

            lu_valid = ($urandom_range(0, 99) < 55);
            lu_rd    = REG_AW'($urandom_range(0, 7));
            lu_wd    = $urandom;

            rst_n = !do_rst;
            model_cycle(do_rst);
        end
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (n_force == 0)
            chk("force_seen", 32'(n_force), 32'd1);
        if (n_rst_held == 0)
            chk("reset_while_held_seen", 32'(n_rst_held), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 register file in a multi-cycle/pipelined RV32 core.
- Shares the register file's single write port between two sources: the in-order pipeline writeback and a long-latency unit (MDU or slow load), with the pipeline writeback having priority.
- Tracks the destination registers of in-flight long-latency operations and raises an issue stall on RAW or WAW hazards against them.
- Drives the register file's wen/wR/wD directly.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5.
- STARVE_LIMIT, 4, maximum number of cycles a buffered long result waits before it forces a writeback slot; legal range 2..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  instruction in decode is attempting issue.
- iss_rs1  in  5  source register 1.
- iss_rs2  in  5  source register 2.
- iss_use_rs1  in  1  instruction reads rs1.
- iss_use_rs2  in  1  instruction reads rs2.
- iss_rd  in  5  destination register.
- iss_long  in  1  instruction's result comes from the long-latency unit.
- iss_stall  out  1  hold decode; the instruction does not issue this cycle.
- wb_valid  in  1  pipeline writeback has a result this cycle.
- wb_we  in  1  the pipeline result writes the register file.
- wb_rd  in  5  pipeline writeback destination.
- wb_wd  in  32  pipeline writeback data.
- wb_hold  out  1  pipeline must freeze WB this cycle; wb_* is re-presented next cycle.
- lu_valid  in  1  long unit presents a result.
- lu_rd  in  5  long unit destination.
- lu_wd  in  32  long unit data.
- lu_ready  out  1  scheduler accepts the long-unit result.
- rf_wen  out  1  register file write enable.
- rf_wr  out  5  register file write address.
- rf_wd  out  32  register file write data.

Behaviour:
- Scoreboard pend[31:0]:
  - pend[0] is always 0.
  - Set at the clock edge when iss_valid & iss_long & !iss_stall & iss_rd != 0.
  - Cleared at the edge ending the cycle in which the buffered long result writes the register file.
- iss_stall (combinational) = iss_valid & ((iss_use_rs1 & pend[rs1]) | (iss_use_rs2 & pend[rs2]) | pend[rd]).
  - There is no same-cycle bypass: a register being written this cycle still stalls.
  - Because of the WAW term, a set and a clear of the same bit never coincide.
- Pipeline slot is free when !wb_valid | !wb_we | wb_rd == 0.
- Pipeline write path (when wb_hold = 0): rf_wen = wb_valid & wb_we & wb_rd != 0, rf_wr = wb_rd, rf_wd = wb_wd, passed through combinationally. Writes to x0 are always suppressed.
- Buffer FSM (1-entry buffer holding rd and data, plus a starve counter):
  - EMPTY:
    - lu_ready = 1.
    - On lu_valid, capture lu_rd/lu_wd and go to HELD with counter = 0.
  - HELD:
    - lu_ready = 0.
    - If the slot is free: rf_wen = (buf_rd != 0), rf_wr = buf_rd, rf_wd = buf_wd; clear pend[buf_rd]; go to EMPTY.
    - Otherwise increment the counter. When the counter == STARVE_LIMIT-1, go to FORCE.
  - FORCE:
    - wb_hold = 1.
    - The buffer writes the register file (rd = 0 still suppressed) and clears its pend bit.
    - The pipeline write is masked this cycle; go to EMPTY.
- Latency: a result accepted at edge N writes the register file during cycle N+1 at the earliest and at most STARVE_LIMIT+1 cycles after acceptance. The matching pend bit clears at the end of the write cycle.
- A long result whose pend bit is not set is still written; its clear is a no-op.
- wb_hold is 0 outside FORCE. rf_wen is never asserted for two sources in the same cycle.
- Reset (asynchronous, also mid-operation):
  - pend = 0, state = EMPTY, counter = 0, buffer contents discarded.
  - Outputs during reset: rf_wen = 0, wb_hold = 0, lu_ready = 1, iss_stall = 0.

Decomposition:
- Shared package rv_pkg: XLEN, REG_AW = 5, NREG = 32, the buffer state enum {EMPTY, HELD, FORCE}.
- One natural sub-module, rf_scoreboard: the pend vector, set/clear logic and the hazard compare. The arbiter and FSM stay in rf_wb_sched.

Test Plan:
- Issue long op, rd = 5; next cycle issue add reading rs1 = 5 -> iss_stall = 1. Then lu result (rd 5, 0xDEADBEEF) with no wb traffic -> rf_wen = 1, rf_wr = 5 the cycle after acceptance; pend[5] clears; stall drops one cycle later.
- Long result buffered while wb_valid & wb_we with rd ≠ 0 every cycle, STARVE_LIMIT = 4 -> wb_hold = 1 exactly on the 5th cycle after acceptance; buffer written; pipeline write for that cycle deferred and performed next cycle.
- Buffer HELD while lu_valid is asserted again -> lu_ready = 0 and no capture; the second result is accepted the cycle after the buffer drains.
- Issue long op with rd = 0 -> pend unchanged. Long result with rd = 0 -> accepted, rf_wen stays 0. wb_rd = 0 with wb_we = 1 -> rf_wen = 0 and the buffer drains in that slot.
- WAW: long op to x7 pending; issue another instruction with rd = 7 and no source use -> iss_stall = 1 until x7 is written.
- Assert rst_n low while in HELD with pend[9] set -> pend = 0, lu_ready = 1, wb_hold = 0, and no register file write after release.
